mc_control_fsm: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory port that uses a ready handshake.
- Replaces simulation-only syscall exit with a real HALT state and adds a memory-timeout trap and a retired-instruction counter.
- Sits between the instruction register/datapath muxes and the unified memory port.

---
 rtl/mc_control_fsm.sv | 396 +++++++++++++++++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//
// Multi-cycle MIPS control unit. Each instruction is walked through
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] over one shared instruction/data
// memory port with a ready handshake. SYSCALL with the exit code parks the
// machine in HALT. Unsupported encodings and memory stalls that outlast
// MEM_TIMEOUT park it in TRAP with a cause code. Every completed instruction
// bumps the retired-instruction counter.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   instr[31:0]    instruction register contents, valid from DECODE onward
//   vreg[31:0]     current $v0 value, selects the SYSCALL service
//   mem_ready      memory completes the current request this cycle
//   mem_req        memory request (FETCH and MEM)
//   mem_we         write strobe, qualified by mem_req
//   i_or_d         address select: 0 = PC, 1 = ALU output register
//   ir_write       load the instruction register
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if the branch condition holds
//   branch_ne      1 = BNE sense, 0 = BEQ sense
//   pc_src[1:0]    0 = ALU, 1 = ALU out (branch target), 2 = jump target, 3 = rs
//   alu_src_a      0 = PC, 1 = rs
//   alu_src_b[1:0] 0 = rt, 1 = const 4, 2 = sext imm, 3 = sext imm << 2
//   alu_op[2:0]    010 add, 110 sub, 000 and, 001 or, 111 slt
//   reg_write      register file write
//   reg_dst[1:0]   0 = rt, 1 = rd, 2 = $31
//   wb_sel[1:0]    0 = ALU, 1 = memory data, 2 = PC
//   sys_puts       one-cycle pulse for the print-string service
//   halted         sticky, set in HALT
//   trap           sticky, set in TRAP
//   trap_cause[1:0] 1 = illegal instruction, 2 = memory timeout
//   instret[CNT_W-1:0] retired-instruction count, wraps
//   state[2:0]     current state encoding
// -----------------------------------------------------------------------------
module mc_control_fsm #(
   parameter logic [31:0] EXIT_CODE   = 32'd10,
   parameter logic [31:0] PUTS_CODE   = 32'd4,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TO_W        = 8,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr,
   input  logic [31:0]      vreg,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             branch_ne,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wb_sel,
   output logic             sys_puts,
   output logic             halted,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   // Primary opcodes
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   // SPECIAL function codes
   localparam logic [5:0] FN_NOP     = 6'h00;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUB     = 6'h22;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_SLT     = 6'h2A;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Trap causes
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   // Timeout disabled entirely when MEM_TIMEOUT is zero.
   localparam bit             TO_EN    = (MEM_TIMEOUT != 0);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

   state_t            state_q, state_n;
   logic [1:0]        cause_q, cause_n;
   logic [CNT_W-1:0]  instret_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic              retire;
   logic              waiting;
   logic              timeout_hit;

   // ---------------------------------------------------------------------------
   // Instruction classification
   // ---------------------------------------------------------------------------
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       is_special;
   logic       is_nop;
   logic       is_syscall;
   logic       is_jr;
   logic       is_r_alu;
   logic [2:0] r_alu_op;
   logic       is_imm_alu;
   logic [2:0] i_alu_op;
   logic       is_load;
   logic       is_store;
   logic       is_branch;
   logic       is_jump;
   logic       is_jal;

   assign opcode     = instr[31:26];
   assign funct      = instr[5:0];
   assign is_special = (opcode == OP_SPECIAL);

   // Register fields and immediates are consumed by the datapath, not here.
   logic unused_instr_fields;
   assign unused_instr_fields = ^instr[25:6];

   // NOTE: every combinational output gets a default before any branch, so
   // no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      is_nop     = 1'b0;
      is_syscall = 1'b0;
      is_jr      = 1'b0;
      is_r_alu   = 1'b0;
      r_alu_op   = ALU_ADD;
      if (is_special) begin
         case (funct)
            FN_NOP:     is_nop     = 1'b1;
            FN_SYSCALL: is_syscall = 1'b1;
            FN_JR:      is_jr      = 1'b1;
            FN_ADD,
            FN_ADDU:    is_r_alu   = 1'b1;
            FN_SUB:     begin is_r_alu = 1'b1; r_alu_op = ALU_SUB; end
            FN_AND:     begin is_r_alu = 1'b1; r_alu_op = ALU_AND; end
            FN_OR:      begin is_r_alu = 1'b1; r_alu_op = ALU_OR;  end
            FN_SLT:     begin is_r_alu = 1'b1; r_alu_op = ALU_SLT; end
            default:    ;
         endcase
      end
   end

   always_comb begin
      is_imm_alu = 1'b0;
      i_alu_op   = ALU_ADD;
      is_load    = 1'b0;
      is_store   = 1'b0;
      is_branch  = 1'b0;
      is_jump    = 1'b0;
      is_jal     = 1'b0;
      case (opcode)
         OP_ADDI,
         OP_ADDIU,
         OP_LUI:   is_imm_alu = 1'b1;
         OP_ORI:   begin is_imm_alu = 1'b1; i_alu_op = ALU_OR;  end
         OP_SLTIU: begin is_imm_alu = 1'b1; i_alu_op = ALU_SLT; end
         OP_LW:    is_load    = 1'b1;
         OP_SW:    is_store   = 1'b1;
         OP_BEQ,
         OP_BNE:   is_branch  = 1'b1;
         OP_J:     is_jump    = 1'b1;
         OP_JAL:   begin is_jump = 1'b1; is_jal = 1'b1; end
         default:  ;
      endcase
   end

   // A wait cycle that finds the counter already at the limit is the last
   // one tolerated; the machine traps instead of waiting again.
   assign timeout_hit = TO_EN && (to_cnt_q == TO_LIMIT) && !mem_ready;

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_n       = state_q;
      cause_n       = cause_q;
      retire        = 1'b0;
      waiting       = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      pc_src        = 2'd0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = 3'b000;
      reg_write     = 1'b0;
      reg_dst       = 2'd0;
      wb_sel        = 2'd0;
      sys_puts      = 1'b0;
      halted        = 1'b0;
      trap          = 1'b0;

      case (state_q)
         S_FETCH: begin
            // ALU computes PC+4 while the instruction is read.
            mem_req   = 1'b1;
            alu_src_b = 2'd1;
            alu_op    = ALU_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_n  = S_DECODE;
            end else begin
               waiting = 1'b1;
               if (timeout_hit) begin
                  state_n = S_TRAP;
                  cause_n = CAUSE_TIMEOUT;
               end
            end
         end

         S_DECODE: begin
            // Speculative branch target; the datapath latches it into ALUOut.
            alu_src_b = 2'd3;
            alu_op    = ALU_ADD;
            if (is_nop) begin
               retire  = 1'b1;
               state_n = S_FETCH;
            end else if (is_syscall) begin
               retire = 1'b1;
               if (vreg == EXIT_CODE) begin
                  state_n = S_HALT;
               end else begin
                  sys_puts = (vreg == PUTS_CODE);
                  state_n  = S_FETCH;
               end
            end else if (is_r_alu || is_jr || is_imm_alu || is_load ||
                         is_store || is_branch || is_jump) begin
               state_n = S_EXEC;
            end else begin
               state_n = S_TRAP;
               cause_n = CAUSE_ILLEGAL;
            end
         end

         S_EXEC: begin
            if (is_r_alu) begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd0;
               alu_op    = r_alu_op;
               state_n   = S_WB;
            end else if (is_imm_alu) begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
               alu_op    = i_alu_op;
               state_n   = S_WB;
            end else if (is_load || is_store) begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
               alu_op    = ALU_ADD;
               state_n   = S_MEM;
            end else if (is_branch) begin
               alu_src_a     = 1'b1;
               alu_src_b     = 2'd0;
               alu_op        = ALU_SUB;
               pc_write_cond = 1'b1;
               pc_src        = 2'd1;
               branch_ne     = (opcode == OP_BNE);
               retire        = 1'b1;
               state_n       = S_FETCH;
            end else if (is_jump) begin
               pc_write = 1'b1;
               pc_src   = 2'd2;
               if (is_jal) begin
                  reg_write = 1'b1;
                  reg_dst   = 2'd2;
                  wb_sel    = 2'd2;
               end
               retire  = 1'b1;
               state_n = S_FETCH;
            end else if (is_jr) begin
               pc_write = 1'b1;
               pc_src   = 2'd3;
               retire   = 1'b1;
               state_n  = S_FETCH;
            end else begin
               // Instruction register changed under us after DECODE.
               state_n = S_TRAP;
               cause_n = CAUSE_ILLEGAL;
            end
         end

         S_MEM: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            mem_we  = is_store;
            if (mem_ready) begin
               if (is_store) begin
                  retire  = 1'b1;
                  state_n = S_FETCH;
               end else begin
                  state_n = S_WB;
               end
            end else begin
               waiting = 1'b1;
               if (timeout_hit) begin
                  state_n = S_TRAP;
                  cause_n = CAUSE_TIMEOUT;
               end
            end
         end

         S_WB: begin
            reg_write = 1'b1;
            reg_dst   = is_special ? 2'd1 : 2'd0;
            wb_sel    = is_load    ? 2'd1 : 2'd0;
            retire    = 1'b1;
            state_n   = S_FETCH;
         end

         S_HALT: halted = 1'b1;

         S_TRAP: trap = 1'b1;

         default: begin
            // Unused encoding 7: recover into a visible illegal-state trap.
            state_n = S_TRAP;
            cause_n = CAUSE_ILLEGAL;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State, counters and trap cause
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         cause_q   <= 2'd0;
         instret_q <= '0;
         to_cnt_q  <= '0;
      end else begin
         state_q <= state_n;
         cause_q <= cause_n;
         if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
         end
         // Cleared whenever not stalled, which covers entry to FETCH/MEM
         // and the completing mem_ready cycle.
         if (waiting) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
         end else begin
            to_cnt_q <= '0;
         end
      end
   end

   assign state      = state_q;
   assign trap_cause = cause_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
//
// Directed bench for mc_control_fsm. Each instruction scenario pushes the
// per-cycle expectation (state, full control vector, instret) plus the inputs
// for that cycle onto a scoreboard queue; run_sb() then drives the inputs on
// the falling edge and compares shortly after. The DUT runs with
// MEM_TIMEOUT = 5 so the timeout trap can be reached quickly.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;
   localparam logic [2:0] ST_TRAP   = 3'd6;

   localparam logic [2:0] A_ADD = 3'b010;
   localparam logic [2:0] A_SUB = 3'b110;
   localparam logic [2:0] A_AND = 3'b000;
   localparam logic [2:0] A_OR  = 3'b001;
   localparam logic [2:0] A_SLT = 3'b111;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] wb_sel;
      logic       sys_puts;
      logic       halted;
      logic       trap;
      logic [1:0] trap_cause;
   } ctl_t;

   typedef struct {
      string       tag;
      logic        rdy;
      logic [31:0] ins;
      logic [31:0] vr;
      logic [2:0]  st;
      ctl_t        ctl;
      logic [31:0] ir;
   } step_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] vreg = '0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
   logic        branch_ne, alu_src_a, reg_write, sys_puts, halted, trap;
   logic [1:0]  pc_src, alu_src_b, reg_dst, wb_sel, trap_cause;
   logic [2:0]  alu_op, state;
   logic [31:0] instret;

   ctl_t        act;
   step_t       sb[$];
   logic [31:0] cur_instr = '0;
   logic [31:0] cur_vreg = '0;
   logic [31:0] exp_ir = '0;
   int          n_tests = 0;
   int          n_fail = 0;

   mc_control_fsm #(
      .EXIT_CODE   (32'd10),
      .PUTS_CODE   (32'd4),
      .MEM_TIMEOUT (5),
      .TO_W        (8),
      .CNT_W       (32)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr         (instr),
      .vreg          (vreg),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .i_or_d        (i_or_d),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .branch_ne     (branch_ne),
      .pc_src        (pc_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .reg_write     (reg_write),
      .reg_dst       (reg_dst),
      .wb_sel        (wb_sel),
      .sys_puts      (sys_puts),
      .halted        (halted),
      .trap          (trap),
      .trap_cause    (trap_cause),
      .instret       (instret),
      .state         (state)
   );

   always #5 clk = ~clk;

   always_comb begin
      act               = '0;
      act.mem_req       = mem_req;
      act.mem_we        = mem_we;
      act.i_or_d        = i_or_d;
      act.ir_write      = ir_write;
      act.pc_write      = pc_write;
      act.pc_write_cond = pc_write_cond;
      act.branch_ne     = branch_ne;
      act.pc_src        = pc_src;
      act.alu_src_a     = alu_src_a;
      act.alu_src_b     = alu_src_b;
      act.alu_op        = alu_op;
      act.reg_write     = reg_write;
      act.reg_dst       = reg_dst;
      act.wb_sel        = wb_sel;
      act.sys_puts      = sys_puts;
      act.halted        = halted;
      act.trap          = trap;
      act.trap_cause    = trap_cause;
   end

   // Expected control vectors, written straight from the state tables.
   function automatic ctl_t k_fetch(logic rdy);
      ctl_t c = '0;
      c.mem_req = 1'b1; c.alu_src_b = 2'd1; c.alu_op = A_ADD;
      c.ir_write = rdy; c.pc_write = rdy;
      return c;
   endfunction

   function automatic ctl_t k_decode(logic puts);
      ctl_t c = '0;
      c.alu_src_b = 2'd3; c.alu_op = A_ADD; c.sys_puts = puts;
      return c;
   endfunction

   function automatic ctl_t k_exec_r(logic [2:0] op);
      ctl_t c = '0;
      c.alu_src_a = 1'b1; c.alu_src_b = 2'd0; c.alu_op = op;
      return c;
   endfunction

   function automatic ctl_t k_exec_i(logic [2:0] op);
      ctl_t c = '0;
      c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = op;
      return c;
   endfunction

   function automatic ctl_t k_exec_br(logic bne);
      ctl_t c = '0;
      c.alu_src_a = 1'b1; c.alu_src_b = 2'd0; c.alu_op = A_SUB;
      c.pc_write_cond = 1'b1; c.pc_src = 2'd1; c.branch_ne = bne;
      return c;
   endfunction

   function automatic ctl_t k_exec_j(logic link);
      ctl_t c = '0;
      c.pc_write = 1'b1; c.pc_src = 2'd2;
      if (link) begin
         c.reg_write = 1'b1; c.reg_dst = 2'd2; c.wb_sel = 2'd2;
      end
      return c;
   endfunction

   function automatic ctl_t k_exec_jr();
      ctl_t c = '0;
      c.pc_write = 1'b1; c.pc_src = 2'd3;
      return c;
   endfunction

   function automatic ctl_t k_mem(logic we);
      ctl_t c = '0;
      c.mem_req = 1'b1; c.i_or_d = 1'b1; c.mem_we = we;
      return c;
   endfunction

   function automatic ctl_t k_wb(logic rtype, logic load);
      ctl_t c = '0;
      c.reg_write = 1'b1;
      c.reg_dst = rtype ? 2'd1 : 2'd0;
      c.wb_sel = load ? 2'd1 : 2'd0;
      return c;
   endfunction

   function automatic ctl_t k_halt();
      ctl_t c = '0;
      c.halted = 1'b1;
      return c;
   endfunction

   function automatic ctl_t k_trap(logic [1:0] cause);
      ctl_t c = '0;
      c.trap = 1'b1; c.trap_cause = cause;
      return c;
   endfunction

   function automatic void sb_push(string tag, logic rdy, logic [2:0] st, ctl_t c);
      step_t s;
      s.tag = tag; s.rdy = rdy; s.ins = cur_instr; s.vr = cur_vreg;
      s.st = st; s.ctl = c; s.ir = exp_ir;
      sb.push_back(s);
   endfunction

   // Drain the scoreboard: one entry per clock cycle.
   task automatic run_sb();
      step_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         mem_ready = e.rdy;
         instr     = e.ins;
         vreg      = e.vr;
         #1;
         n_tests++;
         assert (state === e.st) else begin
            n_fail++;
            $error("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
         end
         n_tests++;
         assert (act === e.ctl) else begin
            n_fail++;
            $error("FAIL %s ctl: got %h expected %h", e.tag, act, e.ctl);
         end
         n_tests++;
         assert (instret === e.ir) else begin
            n_fail++;
            $error("FAIL %s instret: got %0d expected %0d", e.tag, instret, e.ir);
         end
      end
   endtask

   // Assert reset wherever the machine is, check the effect without waiting
   // for a clock, then release just after a rising edge.
   task automatic reset_and_check(string tag);
      rst_n = 1'b0;
      mem_ready = 1'b0;
      #1;
      n_tests++;
      assert (state === ST_FETCH) else begin
         n_fail++;
         $error("FAIL %s state: got %0d expected %0d", tag, state, ST_FETCH);
      end
      n_tests++;
      assert (act === k_fetch(1'b0)) else begin
         n_fail++;
         $error("FAIL %s ctl: got %h expected %h", tag, act, k_fetch(1'b0));
      end
      n_tests++;
      assert (instret === 32'd0) else begin
         n_fail++;
         $error("FAIL %s instret: got %0d expected 0", tag, instret);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_ir = '0;
   endtask

   task automatic r_type(string tag, logic [31:0] ins, logic [2:0] op);
      cur_instr = ins;
      sb_push({tag, "_f"}, 1'b1, ST_FETCH, k_fetch(1'b1));
      sb_push({tag, "_d"}, 1'b1, ST_DECODE, k_decode(1'b0));
      sb_push({tag, "_e"}, 1'b1, ST_EXEC, k_exec_r(op));
      sb_push({tag, "_wb"}, 1'b1, ST_WB, k_wb(1'b1, 1'b0));
      exp_ir++;
      run_sb();
   endtask

   task automatic i_type(string tag, logic [31:0] ins, logic [2:0] op);
      cur_instr = ins;
      sb_push({tag, "_f"}, 1'b1, ST_FETCH, k_fetch(1'b1));
      sb_push({tag, "_d"}, 1'b1, ST_DECODE, k_decode(1'b0));
      sb_push({tag, "_e"}, 1'b1, ST_EXEC, k_exec_i(op));
      sb_push({tag, "_wb"}, 1'b1, ST_WB, k_wb(1'b0, 1'b0));
      exp_ir++;
      run_sb();
   endtask

   task automatic single_exec(string tag, logic [31:0] ins, ctl_t ex);
      cur_instr = ins;
      sb_push({tag, "_f"}, 1'b1, ST_FETCH, k_fetch(1'b1));
      sb_push({tag, "_d"}, 1'b1, ST_DECODE, k_decode(1'b0));
      sb_push({tag, "_e"}, 1'b1, ST_EXEC, ex);
      exp_ir++;
      run_sb();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2;
      reset_and_check("reset");

      // ADD, memory always ready
      r_type("add", 32'h012A4020, A_ADD);

      // LW with three stall cycles in MEM
      cur_instr = 32'h8C880004;
      sb_push("lw_f", 1'b1, ST_FETCH, k_fetch(1'b1));
      sb_push("lw_d", 1'b1, ST_DECODE, k_decode(1'b0));
      sb_push("lw_e", 1'b1, ST_EXEC, k_exec_i(A_ADD));
      for (int i = 0; i < 3; i++) sb_push("lw_mwait", 1'b0, ST_MEM, k_mem(1'b0));
      sb_push("lw_mdone", 1'b1, ST_MEM, k_mem(1'b0));
      sb_push("lw_wb", 1'b1, ST_WB, k_wb(1'b0, 1'b1));
      exp_ir++;
      run_sb();

      single_exec("bne", 32'h15090003, k_exec_br(1'b1));

      // SYSCALL puts, with two fetch stalls first
      cur_instr = 32'h0000000C;
      cur_vreg  = 32'd4;
      sb_push("puts_fwait", 1'b0, ST_FETCH, k_fetch(1'b0));
      sb_push("puts_fwait", 1'b0, ST_FETCH, k_fetch(1'b0));
      sb_push("puts_f", 1'b1, ST_FETCH, k_fetch(1'b1));
      sb_push("puts_d", 1'b1, ST_DECODE, k_decode(1'b1));
      exp_ir++;
      run_sb();
      cur_vreg = 32'd0;

      single_exec("jal", 32'h0C000010, k_exec_j(1'b1));
      r_type("sub", 32'h012A4022, A_SUB);
      r_type("slt", 32'h012A402A, A_SLT);
      r_type("and", 32'h012A4024, A_AND);
      i_type("ori", 32'h35280007, A_OR);
      i_type("sltiu", 32'h2D280007, A_SLT);
      single_exec("beq", 32'h11090003, k_exec_br(1'b0));
      single_exec("jr", 32'h03E00008, k_exec_jr());

      // NOP retires straight from DECODE
      cur_instr = 32'h00000000;
      sb_push("nop_f", 1'b1, ST_FETCH, k_fetch(1'b1));
      sb_push("nop_d", 1'b1, ST_DECODE, k_decode(1'b0));
      exp_ir++;
      run_sb();

      // SYSCALL with an unrecognised service code: no pulse, no halt
      cur_instr = 32'h0000000C;
      cur_vreg  = 32'd7;
      sb_push("sys7_f", 1'b1, ST_FETCH, k_fetch(1'b1));
      sb_push("sys7_d", 1'b1, ST_DECODE, k_decode(1'b0));
      exp_ir++;
      run_sb();
      cur_vreg = 32'd0;

      // SW with one stall
      cur_instr = 32'hAC880008;
      sb_push("sw_f", 1'b1, ST_FETCH, k_fetch(1'b1));
      sb_push("sw_d", 1'b1, ST_DECODE, k_decode(1'b0));
      sb_push("sw_e", 1'b1, ST_EXEC, k_exec_i(A_ADD));
      sb_push("sw_mwait", 1'b0, ST_MEM, k_mem(1'b1));
      sb_push("sw_mdone", 1'b1, ST_MEM, k_mem(1'b1));
      exp_ir++;
      run_sb();
      sb_push("post_sw_f", 1'b0, ST_FETCH, k_fetch(1'b0));
      run_sb();

      // Reset in the middle of a stalled SW
      sb_push("sw2_f", 1'b1, ST_FETCH, k_fetch(1'b1));
      sb_push("sw2_d", 1'b1, ST_DECODE, k_decode(1'b0));
      sb_push("sw2_e", 1'b1, ST_EXEC, k_exec_i(A_ADD));
      sb_push("sw2_mwait", 1'b0, ST_MEM, k_mem(1'b1));
      run_sb();
      reset_and_check("reset_mid_mem");

      // SYSCALL exit -> HALT, mem_ready toggling is ignored
      cur_instr = 32'h0000000C;
      cur_vreg  = 32'd10;
      sb_push("exit_f", 1'b1, ST_FETCH, k_fetch(1'b1));
      sb_push("exit_d", 1'b1, ST_DECODE, k_decode(1'b0));
      exp_ir++;
      for (int i = 0; i < 22; i++) sb_push("halt_hold", logic'(i % 2), ST_HALT, k_halt());
      run_sb();
      cur_vreg = 32'd0;
      @(negedge clk);
      reset_and_check("reset_after_halt");

      // Illegal opcode 0x3F
      cur_instr = 32'hFC000000;
      sb_push("illop_f", 1'b1, ST_FETCH, k_fetch(1'b1));
      sb_push("illop_d", 1'b1, ST_DECODE, k_decode(1'b0));
      for (int i = 0; i < 4; i++) sb_push("illop_trap", 1'b1, ST_TRAP, k_trap(2'd1));
      run_sb();
      @(negedge clk);
      reset_and_check("reset_after_trap");

      // Illegal SPECIAL funct (BREAK)
      cur_instr = 32'h0000000D;
      sb_push("illfn_f", 1'b1, ST_FETCH, k_fetch(1'b1));
      sb_push("illfn_d", 1'b1, ST_DECODE, k_decode(1'b0));
      for (int i = 0; i < 2; i++) sb_push("illfn_trap", 1'b0, ST_TRAP, k_trap(2'd1));
      run_sb();
      @(negedge clk);
      reset_and_check("reset_before_timeout");

      // Fetch timeout: counter reaches 5 with mem_ready still low
      cur_instr = 32'h012A4020;
      for (int i = 0; i < 6; i++) sb_push("to_fwait", 1'b0, ST_FETCH, k_fetch(1'b0));
      for (int i = 0; i < 3; i++) sb_push("to_trap", 1'b1, ST_TRAP, k_trap(2'd2));
      run_sb();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
